cmd_proc: RTL and testbench
===========================

# cmd_proc

Command processor sitting directly downstream of the UART wrapper. It consumes each 16-bit command the wrapper presents on `cmd`/`cmd_rdy`, acknowledges it with `clr_cmd_rdy`, and executes it against a 16-entry × 8-bit register file. It then returns a single 8-bit response through the wrapper's `send_resp`/`resp` transmit handshake and waits for `resp_sent` before accepting the next command.

## Interface
- `TIMEOUT_CYC`, default 4096: cycles allowed in WAIT for `resp_sent` (used only when `CMD_TIMEOUT_EN` is defined).
- `clk` input, 1: system clock; all logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `cmd_rdy` input, 1: the wrapper holds a complete command.
- `cmd` input, 16: command word. `[15:12]` opcode, `[11:8]` register address, `[7:0]` data.
- `clr_cmd_rdy` output, 1: one-cycle pulse that consumes the command.
- `send_resp` output, 1: one-cycle pulse that starts transmission of `resp`.
- `resp` output, 8: response byte, held stable from SEND until the next EXEC.
- `resp_sent` input, 1: the wrapper has finished transmitting the response.
- `rd_addr` input, 4: side read-port address, for the rest of the design.
- `rd_data` output, 8: combinational value of `reg[rd_addr]`.
- `timeout_err` output, 1: one-cycle pulse when a WAIT timeout occurs (tied to 0 without `CMD_TIMEOUT_EN`).

## Operation
- **States:** IDLE, EXEC, SEND, WAIT.
- **IDLE:** if `cmd_rdy` = 1, latch `cmd` and go to EXEC. `clr_cmd_rdy` is high for exactly the EXEC cycle.
- **EXEC:** decode the latched opcode, commit any register update, load `resp`, then go to SEND.
  - 0x1 WRITE: `reg[a]` ← data; `resp` = 0xA5 (ACK).
  - 0x2 READ: `resp` = `reg[a]`.
  - 0x3 INC: `reg[a]` ← `reg[a]` + 1, modulo 256 (0xFF wraps to 0x00); `resp` = the new value.
  - 0x4 PING: `resp` = data; no register change.
  - 0x5 CLEAR: all 16 registers ← 0x00; `resp` = 0xA5.
  - All other opcodes: `resp` = 0xEE (NAK); no register change.
- **SEND:** `send_resp` = 1 for one cycle, then go to WAIT.
- **WAIT:** when `resp_sent` = 1, go to IDLE.
- **Ignored inputs:**
  - `cmd_rdy` outside IDLE is ignored; the wrapper keeps the command pending and it is taken on return to IDLE.
  - `resp_sent` outside WAIT is ignored.
- **Read port:** `rd_data` reflects the pre-edge array contents. A write in the same cycle becomes visible the cycle after EXEC.
- **Reset values:**
  - state IDLE;
  - all registers 0x00;
  - `resp` = 0x00;
  - `clr_cmd_rdy`, `send_resp`, `timeout_err` = 0.
- **Reset mid-operation:** reset in any state aborts the transaction; no partial register update survives. The wrapper's `cmd_rdy` is not cleared by this block.

## Timing
- **Cycle-by-cycle sequence:**
  - Cycle N: `cmd_rdy` is sampled high in IDLE.
  - Cycle N+1: EXEC; `clr_cmd_rdy` = 1.
  - Edge ending N+1: the register write commits and `resp` is loaded.
  - Cycle N+2: SEND; `send_resp` = 1 and `resp` is valid.
  - N+3 onward: WAIT.
- **Loop-back:** `resp_sent` sampled high in cycle M puts IDLE at M+1. A pending `cmd_rdy` at M+1 yields EXEC at M+2.
- **Throughput:** minimum 4 cycles per command, plus the UART transmit time.
- All outputs except `rd_data` are registered or decoded from state; there are no combinational input-to-output paths.

## Configuration
- **`CMD_TIMEOUT_EN` defined:**
  - A 13-bit-or-wider counter clears on WAIT entry and increments each WAIT cycle.
  - Reaching `TIMEOUT_CYC` without `resp_sent` forces IDLE and pulses `timeout_err` for one cycle.
  - If `resp_sent` arrives on the same cycle the limit is reached, `resp_sent` wins and no error is flagged.
- **`CMD_TIMEOUT_EN` undefined:**
  - WAIT persists indefinitely.
  - No counter is synthesized and `timeout_err` = 0.

## Structure
- **Package `cmd_pkg`:** opcode enum (WRITE=4'h1 … CLEAR=4'h5), `RESP_ACK`=8'hA5, `RESP_NAK`=8'hEE, and the state enum.
- **Sub-module `cmd_regfile`:** 16×8 array with a single write port, a synchronous clear-all, one internal read port for EXEC and one for `rd_addr`, and synchronous reset to zero.

## Test plan
- WRITE then READ: `cmd`=16'h13_5C produces `resp` 0xA5 and `rd_data`@3 = 0x5C; then `cmd`=16'h23_00 produces `resp` 0x5C.
- INC wrap: write 0xFF to reg 7, then `cmd`=16'h37_00 produces `resp` 0x00 and `rd_data`@7 = 0x00; a second INC produces `resp` 0x01.
- NAK and PING: `cmd`=16'hF0_12 produces `resp` 0xEE with registers unchanged; `cmd`=16'h40_9A produces `resp` 0x9A.
- Handshake and back-pressure:
  - Hold `cmd_rdy` high through WAIT: a single `clr_cmd_rdy` pulse, no second EXEC until `resp_sent`.
  - Verify `send_resp` falls exactly 2 cycles after `cmd_rdy` is sampled in IDLE.
- CLEAR and mid-op reset:
  - After writes to regs 0 and 15, `cmd`=16'h50_00 produces `resp` 0xA5 and all `rd_data` = 0.
  - Assert `rst` in WAIT: next cycle is IDLE, `resp` = 0x00, registers are 0.
- Timeout (`CMD_TIMEOUT_EN`, `TIMEOUT_CYC`=16): withhold `resp_sent` and check `timeout_err` pulses once, 16 cycles after WAIT entry; then a new command is accepted.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared types and constants for the command processor.
//   opcode_e : command opcodes carried in cmd[15:12]
//   state_e  : command processor sequencer states
//   RESP_ACK / RESP_NAK : fixed response bytes
package cmd_pkg;

   typedef enum logic [3:0] {
      OP_WRITE = 4'h1,
      OP_READ  = 4'h2,
      OP_INC   = 4'h3,
      OP_PING  = 4'h4,
      OP_CLEAR = 4'h5
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_SEND = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_NAK = 8'hEE;

endpackage

// File: rtl/cmd_if.sv
// cmd_if: handshake between the UART wrapper (master) and cmd_proc (slave).
//   cmd_rdy/cmd        : wrapper holds a complete 16-bit command
//   clr_cmd_rdy        : processor consumes the command (one-cycle pulse)
//   send_resp/resp     : processor starts transmission of the response byte
//   resp_sent          : wrapper has finished transmitting the response
interface cmd_if;
   logic        cmd_rdy;
   logic [15:0] cmd;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;
   logic        resp_sent;

   modport master (output cmd_rdy, cmd, resp_sent, input clr_cmd_rdy, send_resp, resp);
   modport slave  (input cmd_rdy, cmd, resp_sent, output clr_cmd_rdy, send_resp, resp);
endinterface

// File: rtl/cmd_regfile.sv
// cmd_regfile: 16 x 8 register file.
//   clk, rst        : clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata  : single write port
//   clr             : synchronous clear of all entries
//   raddr_a/rdata_a : combinational read port used while executing a command
//   raddr_b/rdata_b : combinational side read port
module cmd_regfile (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic       clr,
   input  logic [3:0] raddr_a,
   output logic [7:0] rdata_a,
   input  logic [3:0] raddr_b,
   output logic [7:0] rdata_b
);

   logic [7:0] mem_r [16];

   // Storage update: reset and clear-all zero every entry, otherwise single write.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < 16; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_r[raddr_a];
   assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/cmd_proc.sv
// cmd_proc: executes wrapper commands against a 16 x 8 register file and
// returns one response byte per command.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : cmd_rdy/cmd/clr_cmd_rdy/send_resp/resp/resp_sent handshake
//   rd_addr       : side read address
//   rd_data       : combinational reg[rd_addr]
//   timeout_err   : one-cycle pulse on a response timeout
// Optional feature: define CMD_TIMEOUT_EN to bound the wait for resp_sent to
// TIMEOUT_CYC cycles; without it the wait is unbounded and timeout_err is 0.
module cmd_proc
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic       clk,
   input  logic       rst,
   cmd_if.slave       bus,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       timeout_err
);

   state_e      state_r;
   state_e      state_nxt_s;
   logic [15:0] cmd_r;
   logic [7:0]  resp_r;
   logic [7:0]  resp_nxt_s;
   logic        clr_r;
   logic        send_r;
   logic        exec_s;
   logic        we_s;
   logic        clr_all_s;
   logic [7:0]  wdata_s;
   logic [7:0]  exec_rdata_s;
   logic        tmo_s;

   assign exec_s = (state_r == ST_EXEC);

   cmd_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (we_s & exec_s),
      .waddr   (cmd_r[11:8]),
      .wdata   (wdata_s),
      .clr     (clr_all_s & exec_s),
      .raddr_a (cmd_r[11:8]),
      .rdata_a (exec_rdata_s),
      .raddr_b (rd_addr),
      .rdata_b (rd_data)
   );

   // Next-state logic; resp_sent takes priority over a simultaneous timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_rdy) state_nxt_s = ST_EXEC;
            else             state_nxt_s = ST_IDLE;
         end
         ST_EXEC: state_nxt_s = ST_SEND;
         ST_SEND: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (bus.resp_sent) state_nxt_s = ST_IDLE;
            else if (tmo_s)    state_nxt_s = ST_IDLE;
            else               state_nxt_s = ST_WAIT;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Opcode decode of the latched command: register update and response byte.
   always_comb begin
      we_s       = 1'b0;
      clr_all_s  = 1'b0;
      wdata_s    = cmd_r[7:0];
      resp_nxt_s = RESP_NAK;
      case (cmd_r[15:12])
         OP_WRITE: begin
            we_s       = 1'b1;
            resp_nxt_s = RESP_ACK;
         end
         OP_READ: resp_nxt_s = exec_rdata_s;
         OP_INC: begin
            we_s       = 1'b1;
            wdata_s    = exec_rdata_s + 8'd1;
            resp_nxt_s = exec_rdata_s + 8'd1;
         end
         OP_PING: resp_nxt_s = cmd_r[7:0];
         OP_CLEAR: begin
            clr_all_s  = 1'b1;
            resp_nxt_s = RESP_ACK;
         end
         default: resp_nxt_s = RESP_NAK;
      endcase
   end

   // State, command latch, response byte and registered handshake pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cmd_r   <= 16'h0000;
         resp_r  <= 8'h00;
         clr_r   <= 1'b0;
         send_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_IDLE && bus.cmd_rdy) cmd_r <= bus.cmd;
         if (exec_s) resp_r <= resp_nxt_s;
         // Pulses are registered from the next state so they align with EXEC/SEND.
         clr_r   <= (state_nxt_s == ST_EXEC);
         send_r  <= (state_nxt_s == ST_SEND);
      end
   end

   assign bus.clr_cmd_rdy = clr_r;
   assign bus.send_resp   = send_r;
   assign bus.resp        = resp_r;

`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 13) ? $clog2(TIMEOUT_CYC + 1) : 13;

   logic [CNT_W-1:0] cnt_r;
   logic             tmo_err_r;

   // Counter value k means this is the (k+1)-th WAIT cycle.
   assign tmo_s = (state_r == ST_WAIT) && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

   // WAIT cycle counter (cleared in SEND so it starts at zero on WAIT entry) and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         tmo_err_r <= 1'b0;
      end else begin
         if (state_r == ST_SEND)      cnt_r <= {CNT_W{1'b0}};
         else if (state_r == ST_WAIT) cnt_r <= cnt_r + CNT_W'(1);
         else                         cnt_r <= cnt_r;
         tmo_err_r <= tmo_s && !bus.resp_sent;
      end
   end

   assign timeout_err = tmo_err_r;
`else
   logic [31:0] unused_timeout_s;

   assign unused_timeout_s = 32'(TIMEOUT_CYC);
   assign tmo_s            = 1'b0;
   assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc: directed-vector bench for cmd_proc with a command-level model
// (register array + response rules) and a per-cycle compare process.
module tb_cmd_proc;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       timeout_err;

   cmd_if bus ();

   cmd_proc #(.TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mreg [16];
   logic [7:0] exp_resp;
   logic       exp_clr, exp_send, exp_tmo;
   bit         chk_en = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Command-level model: apply one command to the register array, return response.
   task automatic model_exec(input logic [15:0] c);
      int a;
      int d;
      a = int'(c[11:8]);
      d = int'(c[7:0]);
      case (int'(c[15:12]))
         1: begin mreg[a] = 8'(d); exp_resp = 8'hA5; end
         2: exp_resp = mreg[a];
         3: begin mreg[a] = 8'((int'(mreg[a]) + 1) % 256); exp_resp = mreg[a]; end
         4: exp_resp = 8'(d);
         5: begin for (int i = 0; i < 16; i++) mreg[i] = 8'h00; exp_resp = 8'hA5; end
         default: exp_resp = 8'hEE;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
      exp_resp = 8'h00;
      exp_clr  = 1'b0;
      exp_send = 1'b0;
      exp_tmo  = 1'b0;
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("clr_cmd_rdy", {7'd0, bus.clr_cmd_rdy}, {7'd0, exp_clr});
         chk("send_resp", {7'd0, bus.send_resp}, {7'd0, exp_send});
         chk("timeout_err", {7'd0, timeout_err}, {7'd0, exp_tmo});
         chk("resp", bus.resp, exp_resp);
         chk("rd_data", rd_data, mreg[rd_addr]);
      end
   end

   // Advance one cycle; the side read address sweeps so every entry is compared.
   task automatic tick();
      @(posedge clk);
      #1;
      rd_addr = rd_addr + 4'd1;
   endtask

   // One command transaction. lit >= 0 pins the response to a literal.
   task automatic do_cmd(input logic [15:0] c, input int lit, input bit hold,
                         input int wcyc, input bit withhold);
      bus.cmd_rdy = 1'b1;
      bus.cmd     = c;
      exp_clr     = 1'b0;
      exp_send    = 1'b0;
      tick();                         // EXEC
      exp_clr = 1'b1;
      if (!hold) bus.cmd_rdy = 1'b0;
      tick();                         // SEND
      exp_clr  = 1'b0;
      exp_send = 1'b1;
      model_exec(c);
      if (lit >= 0) chk("resp_literal", bus.resp, 8'(lit));
      tick();                         // first WAIT cycle
      exp_send = 1'b0;
      if (withhold) begin
         repeat (16) tick();
         exp_tmo = 1'b1;
         tick();
         exp_tmo = 1'b0;
      end else begin
         repeat (wcyc) tick();
         bus.resp_sent = 1'b1;
         tick();                      // back in IDLE
         bus.resp_sent = 1'b0;
      end
   endtask

   // Reset during EXEC (phase 0) or WAIT (phase 1) of a write command.
   task automatic reset_in(input logic [15:0] c, input bit phase);
      bus.cmd_rdy = 1'b1;
      bus.cmd     = c;
      tick();
      exp_clr     = 1'b1;
      bus.cmd_rdy = 1'b0;
      if (phase) begin
         tick();
         exp_clr  = 1'b0;
         exp_send = 1'b1;
         model_exec(c);
         tick();
         exp_send = 1'b0;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("rst_mid_resp", bus.resp, 8'h00);
      rd_addr = c[11:8];
      #1;
      chk("rst_mid_reg", rd_data, 8'h00);
   endtask

   initial begin
      rst           = 1'b1;
      rd_addr       = 4'd0;
      bus.cmd_rdy   = 1'b0;
      bus.cmd       = 16'h0000;
      bus.resp_sent = 1'b0;
      model_reset();
      repeat (3) tick();
      rst    = 1'b0;
      chk("reset_resp", bus.resp, 8'h00);
      chk("reset_clr", {7'd0, bus.clr_cmd_rdy}, 8'h00);
      chk_en = 1'b1;
      repeat (16) tick();

      // WRITE then READ
      do_cmd(16'h135C, 8'hA5, 1'b0, 2, 1'b0);
      rd_addr = 4'd3; #1;
      chk("write_rd3", rd_data, 8'h5C);
      do_cmd(16'h2300, 8'h5C, 1'b0, 0, 1'b0);

      // INC wrap
      do_cmd(16'h17FF, 8'hA5, 1'b0, 1, 1'b0);
      do_cmd(16'h3700, 8'h00, 1'b0, 0, 1'b0);
      rd_addr = 4'd7; #1;
      chk("inc_wrap_rd7", rd_data, 8'h00);
      do_cmd(16'h3700, 8'h01, 1'b0, 3, 1'b0);

      // NAK and PING
      do_cmd(16'hF012, 8'hEE, 1'b0, 0, 1'b0);
      do_cmd(16'h409A, 8'h9A, 1'b0, 0, 1'b0);
      do_cmd(16'h0312, 8'hEE, 1'b0, 0, 1'b0);
      do_cmd(16'h6123, 8'hEE, 1'b0, 0, 1'b0);
      rd_addr = 4'd3; #1;
      chk("nak_keeps_rd3", rd_data, 8'h5C);

      // Back-pressure: cmd_rdy held through WAIT, re-executed only after resp_sent
      do_cmd(16'h4011, 8'h11, 1'b1, 5, 1'b0);
      do_cmd(16'h4011, 8'h11, 1'b0, 0, 1'b0);

      // Long waits: 15 WAIT cycles before resp_sent is the timeout boundary
      do_cmd(16'h4022, 8'h22, 1'b0, 15, 1'b0);
`ifndef CMD_TIMEOUT_EN
      do_cmd(16'h4033, 8'h33, 1'b0, 40, 1'b0);
`endif

      // CLEAR
      do_cmd(16'h10AB, 8'hA5, 1'b0, 0, 1'b0);
      do_cmd(16'h1FCD, 8'hA5, 1'b0, 0, 1'b0);
      rd_addr = 4'd15; #1;
      chk("pre_clear_rd15", rd_data, 8'hCD);
      do_cmd(16'h5000, 8'hA5, 1'b0, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #1;
         chk("clear_all", rd_data, 8'h00);
      end

      // Mid-operation resets, then a command is accepted right away
      do_cmd(16'h1244, 8'hA5, 1'b0, 0, 1'b0);
      reset_in(16'h1977, 1'b1);
      rd_addr = 4'd2; #1;
      chk("rst_clears_rd2", rd_data, 8'h00);
      do_cmd(16'h2900, 8'h00, 1'b0, 0, 1'b0);
      reset_in(16'h1A55, 1'b0);
      do_cmd(16'h2A00, 8'h00, 1'b0, 0, 1'b0);

`ifdef CMD_TIMEOUT_EN
      // Timeout: no resp_sent, error pulse 16 cycles after WAIT entry, then recover
      do_cmd(16'h4066, 8'h66, 1'b0, 0, 1'b1);
      do_cmd(16'h1155, 8'hA5, 1'b0, 0, 1'b0);
      do_cmd(16'h2100, 8'h55, 1'b0, 0, 1'b0);
`endif

      repeat (20) tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
